// File: rtl/fb_pkg.sv
// ---------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the 256x256 RGB framebuffer port arbiter.
//   FB_ADDR_W / FB_PIX_W : pixel address and pixel widths
//   fb_addr_t / fb_pixel_t : address {y,x} and pixel {R,G,B} types
//   fb_arb_state_t       : arbiter sequencer states
//   fb_pack_addr(x, y)   : builds a pixel address from coordinates
// ---------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_ADDR_W = 16;
    localparam int FB_PIX_W  = 36;

    typedef logic [FB_ADDR_W-1:0] fb_addr_t;
    typedef logic [FB_PIX_W-1:0]  fb_pixel_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } fb_arb_state_t;

    // Row-major layout: y selects the line, x the pixel within it.
    function automatic fb_addr_t fb_pack_addr(input logic [7:0] x, input logic [7:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin grant generator with its own rotating priority pointer.
//   iCLK, iRST_N : clock, asynchronous active-low reset
//   iREQ[N]      : request vector
//   iENABLE      : when low no grant is issued
//   iACCEPT      : the current grant was taken; advance the pointer
//   oGNT[N]      : one-hot (or zero) combinational grant
// The first requester at or after the pointer wins; after an accepted
// grant to requester i the pointer moves to (i+1) mod N.
// ---------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         iCLK,
    input  logic         iRST_N,
    input  logic [N-1:0] iREQ,
    input  logic         iENABLE,
    input  logic         iACCEPT,
    output logic [N-1:0] oGNT
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] rrPtr;
    logic [PW-1:0] winIdx;
    logic          found;
    int            idx;

    // Scan N positions starting at the pointer, wrapping by subtraction so
    // non-power-of-two N works without a modulo operator.
    always_comb begin
        oGNT   = '0;
        winIdx = rrPtr;
        found  = 1'b0;
        idx    = 0;
        for (int k = 0; k < N; k++) begin
            idx = int'(rrPtr) + k;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (iENABLE && !found && iREQ[idx]) begin
                oGNT[idx] = 1'b1;
                winIdx    = PW'(idx);
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            rrPtr <= '0;
        end else if (iACCEPT) begin
            if (int'(winIdx) == N - 1) begin
                rrPtr <= '0;
            end else begin
                rrPtr <= winIdx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fb_arbiter.sv
// ---------------------------------------------------------------------------
// fb_arbiter
// Shares the single synchronous framebuffer RAM port between the scan-out
// read stream (absolute priority), a whole-frame clear engine, and N_WR
// round-robin pixel writers.
//   iCLK, iRST_N                 : pixel clock, asynchronous active-low reset
//   iRD_REQ, iRD_ADDR            : scan-out read, one pixel per cycle
//   oRD_VALID, oRD_DATA          : read pixel, 3 cycles after the request
//   iWR_REQ, iWR_ADDR, iWR_DATA  : per-writer pixel write requests
//   oWR_GNT                      : combinational per-writer grant
//   iCLEAR, iCLEAR_COLOR         : start a frame clear with this colour
//   oCLEAR_BUSY, oCLEAR_DONE     : clear in progress / completion pulse
//   oMEM_ADDR, oMEM_WDATA, oMEM_WE : registered RAM port
//   iMEM_RDATA                   : RAM data, one cycle after the address
//   oDBG_STATE                   : current sequencer state
//
// Write handshake: writer i is accepted in a cycle where iWR_REQ[i] and
// oWR_GNT[i] are both high; the grant is purely combinational, so a writer
// holds iWR_REQ/iWR_ADDR/iWR_DATA stable until it sees its grant, and the
// write appears on the RAM port in the following cycle.
// ---------------------------------------------------------------------------
module fb_arbiter #(
    parameter int N_WR      = 2,
    parameter int FB_ADDR_W = fb_pkg::FB_ADDR_W,
    parameter int FB_PIX_W  = fb_pkg::FB_PIX_W
) (
    input  logic                                iCLK,
    input  logic                                iRST_N,
    input  logic                                iRD_REQ,
    input  logic [FB_ADDR_W-1:0]                iRD_ADDR,
    output logic                                oRD_VALID,
    output logic [FB_PIX_W-1:0]                 oRD_DATA,
    input  logic [N_WR-1:0]                     iWR_REQ,
    input  logic [N_WR-1:0][FB_ADDR_W-1:0]      iWR_ADDR,
    input  logic [N_WR-1:0][FB_PIX_W-1:0]       iWR_DATA,
    output logic [N_WR-1:0]                     oWR_GNT,
    input  logic                                iCLEAR,
    input  logic [FB_PIX_W-1:0]                 iCLEAR_COLOR,
    output logic                                oCLEAR_BUSY,
    output logic                                oCLEAR_DONE,
    output logic [FB_ADDR_W-1:0]                oMEM_ADDR,
    output logic [FB_PIX_W-1:0]                 oMEM_WDATA,
    output logic                                oMEM_WE,
    input  logic [FB_PIX_W-1:0]                 iMEM_RDATA,
    output fb_pkg::fb_arb_state_t               oDBG_STATE
);

    import fb_pkg::*;

    fb_arb_state_t          state;
    fb_arb_state_t          stateNext;

    // One spare bit so a runaway counter is caught instead of wrapping.
    logic [FB_ADDR_W:0]     clrCnt;
    logic [FB_PIX_W-1:0]    clrColor;
    logic                   clrStart;
    logic                   clrWrite;
    logic                   clrLast;

    logic                   wrEnable;
    logic                   wrAccept;
    logic [N_WR-1:0]        gnt;
    logic [FB_ADDR_W-1:0]   wrAddrSel;
    logic [FB_PIX_W-1:0]    wrDataSel;

    // Read pipeline: address issued, RAM access, capture.
    logic                   rdPend1;
    logic                   rdPend2;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        stateNext = state;
        case (state)
            ST_IDLE: begin
                if (iCLEAR) begin
                    stateNext = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                if (clrLast || clrCnt[FB_ADDR_W]) begin
                    stateNext = ST_IDLE;
                end
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // A read always steals the port, so both the clear engine and the
    // writers are held off in any cycle with iRD_REQ high.
    always_comb begin
        wrEnable    = 1'b0;
        clrStart    = 1'b0;
        clrWrite    = 1'b0;
        oCLEAR_BUSY = 1'b0;
        case (state)
            ST_IDLE: begin
                wrEnable = !iRD_REQ;
                clrStart = iCLEAR;
            end
            ST_CLEAR: begin
                oCLEAR_BUSY = 1'b1;
                clrWrite    = !iRD_REQ && !clrCnt[FB_ADDR_W];
            end
            default: ;
        endcase
    end

    assign clrLast    = clrWrite && (clrCnt[FB_ADDR_W-1:0] == '1);
    assign oDBG_STATE = state;

    // ---------------- writer arbitration ----------------
    rr_arbiter #(.N(N_WR)) u_rr (
        .iCLK    (iCLK),
        .iRST_N  (iRST_N),
        .iREQ    (iWR_REQ),
        .iENABLE (wrEnable),
        .iACCEPT (wrAccept),
        .oGNT    (gnt)
    );

    assign oWR_GNT  = gnt;
    assign wrAccept = |(iWR_REQ & gnt);

    // Grant is one-hot, so an OR of the gated lanes is the winner's payload.
    always_comb begin
        wrAddrSel = '0;
        wrDataSel = '0;
        for (int i = 0; i < N_WR; i++) begin
            if (gnt[i]) begin
                wrAddrSel = wrAddrSel | iWR_ADDR[i];
                wrDataSel = wrDataSel | iWR_DATA[i];
            end
        end
    end

    // ---------------- datapath ----------------
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            clrCnt      <= '0;
            clrColor    <= '0;
            oCLEAR_DONE <= 1'b0;
            oMEM_ADDR   <= '0;
            oMEM_WDATA  <= '0;
            oMEM_WE     <= 1'b0;
            rdPend1     <= 1'b0;
            rdPend2     <= 1'b0;
            oRD_VALID   <= 1'b0;
            oRD_DATA    <= '0;
        end else begin
            if (clrStart) begin
                clrCnt   <= '0;
                clrColor <= iCLEAR_COLOR;
            end else if (clrWrite) begin
                clrCnt <= clrCnt + 1'b1;
            end
            oCLEAR_DONE <= clrLast;

            if (iRD_REQ) begin
                oMEM_ADDR <= iRD_ADDR;
                oMEM_WE   <= 1'b0;
            end else if (clrWrite) begin
                oMEM_ADDR  <= clrCnt[FB_ADDR_W-1:0];
                oMEM_WDATA <= clrColor;
                oMEM_WE    <= 1'b1;
            end else if (wrAccept) begin
                oMEM_ADDR  <= wrAddrSel;
                oMEM_WDATA <= wrDataSel;
                oMEM_WE    <= 1'b1;
            end else begin
                oMEM_WE <= 1'b0;
            end

            rdPend1   <= iRD_REQ;
            rdPend2   <= rdPend1;
            oRD_VALID <= rdPend2;
            if (rdPend2) begin
                oRD_DATA <= iMEM_RDATA;
            end
        end
    end

endmodule
